// File: rtl/press_pulser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// press_pulser : synchronised, debounced up/down button strobes with repeat
// Revision 1.0
// ----------------------------------------------------------------------------
module press_pulser #(
   parameter int DebounceCycles = 16,
   parameter int RepeatDelay    = 64,
   parameter int RepeatRate     = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic button_up,
   input  logic button_dn,
   output logic countu,
   output logic countd
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } state_e;

   localparam logic [7:0]  c_deb_cycles = 8'(DebounceCycles);
   localparam logic [15:0] c_rep_delay  = 16'(RepeatDelay);
   localparam logic [15:0] c_rep_rate   = 16'(RepeatRate);

   logic [1:0] button;
   logic [1:0] deb;
   logic [1:0] pulse;

   assign button = {button_dn, button_up};
   assign countu = pulse[0];
   assign countd = pulse[1];

   // Channel 0 is the up button, channel 1 the down button.
   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic         sync1_q, sync1_d;
      logic         sync2_q, sync2_d;
      logic         deb_q, deb_d;
      logic [7:0]   dcnt_q, dcnt_d;
      logic [15:0]  rcnt_q, rcnt_d;
      logic [15:0]  rcnt_inc;
      logic         pulse_q, pulse_d;
      state_e       state_q, state_d;
      logic         other_deb;

      assign other_deb = deb[1-ch];
      assign rcnt_inc  = rcnt_q + 16'd1;
      assign deb[ch]   = deb_q;
      assign pulse[ch] = pulse_q;

      always_comb begin
         sync1_d = button[ch];
         sync2_d = sync1_q;
         deb_d   = deb_q;
         dcnt_d  = 8'd0;
         if (sync2_q != deb_q) begin
            if (dcnt_q == c_deb_cycles) begin
               deb_d = sync2_q;
            end else begin
               dcnt_d = dcnt_q + 8'd1;
            end
         end
      end

      // Own release beats lockout, which beats any repeat pulse.
      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         pulse_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (deb_q) begin
                  rcnt_d = 16'd0;
                  if (other_deb) begin
                     state_d = ST_LOCK;
                  end else begin
                     state_d = ST_HELD;
                     pulse_d = 1'b1;
                  end
               end
            end
            ST_HELD: begin
               if (!deb_q) begin
                  state_d = ST_IDLE;
                  rcnt_d  = 16'd0;
               end else if (other_deb) begin
                  state_d = ST_LOCK;
                  rcnt_d  = 16'd0;
               end else if (c_rep_delay != 16'd0) begin
                  if (rcnt_inc == c_rep_delay) begin
                     state_d = ST_REPEAT;
                     rcnt_d  = 16'd0;
                     pulse_d = 1'b1;
                  end else begin
                     rcnt_d = rcnt_inc;
                  end
               end
            end
            ST_REPEAT: begin
               if (!deb_q) begin
                  state_d = ST_IDLE;
                  rcnt_d  = 16'd0;
               end else if (other_deb) begin
                  state_d = ST_LOCK;
                  rcnt_d  = 16'd0;
               end else if (rcnt_inc == c_rep_rate) begin
                  rcnt_d  = 16'd0;
                  pulse_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_inc;
               end
            end
            ST_LOCK: begin
               if (!deb_q) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               rcnt_d  = 16'd0;
            end
         endcase
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            dcnt_q  <= 8'd0;
            rcnt_q  <= 16'd0;
            pulse_q <= 1'b0;
            state_q <= ST_IDLE;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_press_pulser.sv
`default_nettype none
// tb_press_pulser : directed button scenarios checked every cycle against a
// history-based reference model, plus literal pulse-timing expectations.
module tb_press_pulser;

   localparam int D    = 4;
   localparam int RD   = 20;
   localparam int RR   = 8;
   localparam int MAXC = 2048;

   logic clock;
   logic reset;
   logic button_up;
   logic button_dn;
   logic countu;
   logic countd;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   logic s_m   [2][MAXC];
   logic deb_m [2][MAXC];
   logic exp_u = 1'b0;
   logic exp_d = 1'b0;
   int   up_q[$];
   int   dn_q[$];

   press_pulser #(
      .DebounceCycles (D),
      .RepeatDelay    (RD),
      .RepeatRate     (RR)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .button_up (button_up),
      .button_dn (button_dn),
      .countu    (countu),
      .countd    (countd)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_train(input string name, input int q[$], input int base,
                              input int offs[$]);
      check_int({name, "_count"}, q.size(), offs.size());
      for (int i = 0; i < offs.size(); i++) begin
         check_int($sformatf("%s_pulse%0d", name, i),
                   (i < q.size()) ? q[i] - base : -1, offs[i]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Reference model: the debounced level changes once the last D+1 samples
   // since the latest reset all disagree with it; pulses follow from the time
   // since the debounced rise, blocked forever if the other side was ever high.
   initial begin : model
      int   last_rst;
      int   rise   [2];
      logic locked [2];
      logic pe     [2];
      logic flip;
      int   k;
      last_rst = 0;
      for (int c = 0; c < 2; c++) begin
         rise[c]   = 0;
         locked[c] = 1'b0;
         for (int i = 0; i < MAXC; i++) begin
            s_m[c][i]   = 1'b0;
            deb_m[c][i] = 1'b0;
         end
      end
      forever begin
         @(posedge clock);
         cyc = cyc + 1;
         if (cyc >= MAXC) begin
            $display("FAIL model_overflow: got %0d, expected below %0d", cyc, MAXC);
            $fatal(1);
         end
         if (reset) last_rst = cyc;
         s_m[0][cyc] = reset ? 1'b0 : button_up;
         s_m[1][cyc] = reset ? 1'b0 : button_dn;
         for (int c = 0; c < 2; c++) begin
            if (reset) begin
               deb_m[c][cyc] = 1'b0;
            end else begin
               flip = (cyc - 2 - D > last_rst);
               if (flip) begin
                  for (int i = cyc - 2 - D; i <= cyc - 2; i++) begin
                     if (s_m[c][i] == deb_m[c][cyc-1]) flip = 1'b0;
                  end
               end
               deb_m[c][cyc] = flip ? ~deb_m[c][cyc-1] : deb_m[c][cyc-1];
            end
         end
         for (int c = 0; c < 2; c++) begin
            pe[c] = 1'b0;
            if (!reset && deb_m[c][cyc-1]) begin
               k = cyc - (rise[c] + 1);
               pe[c] = !locked[c] &&
                       (k == 0 || (RD != 0 && k >= RD && (k - RD) % RR == 0));
            end
         end
         for (int c = 0; c < 2; c++) begin
            if (deb_m[c][cyc] && !deb_m[c][cyc-1]) begin
               rise[c]   = cyc;
               locked[c] = deb_m[1-c][cyc];
            end else if (deb_m[c][cyc]) begin
               locked[c] = locked[c] | deb_m[1-c][cyc];
            end
         end
         exp_u = pe[0];
         exp_d = pe[1];
      end
   end

   initial begin : compare
      forever begin
         @(negedge clock);
         if (cyc >= 1) begin
            check_bit("countu", countu, exp_u);
            check_bit("countd", countd, exp_d);
            if (countu === 1'b1) up_q.push_back(cyc);
            if (countd === 1'b1) dn_q.push_back(cyc);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      reset     = 1'b1;
      button_up = 1'b1;
      button_dn = 1'b1;

      // Reset held two cycles with both buttons high.
      tick(1);
      #1;
      check_int("reset_countu_0", int'(countu), 0);
      check_int("reset_countd_0", int'(countd), 0);
      tick(1);
      #1;
      check_int("reset_countu_1", int'(countu), 0);
      check_int("reset_countd_1", int'(countd), 0);
      up_q.delete();
      dn_q.delete();
      n = cyc + 1;
      reset     = 1'b0;
      button_dn = 1'b0;
      tick(10);
      button_up = 1'b0;
      tick(20);
      #1;
      check_train("after_reset_up", up_q, n, {7});
      check_int("after_reset_dn_count", dn_q.size(), 0);

      // Clean press.
      up_q.delete();
      dn_q.delete();
      n = cyc + 1;
      button_up = 1'b1;
      tick(10);
      button_up = 1'b0;
      tick(20);
      #1;
      check_train("clean_up", up_q, n, {7});
      check_int("clean_dn_count", dn_q.size(), 0);

      // Bouncing down button.
      up_q.delete();
      dn_q.delete();
      for (int i = 0; i < 4; i++) begin
         button_dn = (i % 2 == 0);
         tick(2);
      end
      n = cyc + 1;
      button_dn = 1'b1;
      tick(12);
      button_dn = 1'b0;
      tick(20);
      #1;
      check_train("bounce_dn", dn_q, n, {7});
      check_int("bounce_up_count", up_q.size(), 0);

      // Auto-repeat.
      up_q.delete();
      dn_q.delete();
      n = cyc + 1;
      button_up = 1'b1;
      tick(60);
      button_up = 1'b0;
      tick(30);
      #1;
      check_train("repeat_up", up_q, n, {7, 27, 35, 43, 51, 59});

      // Simultaneous press, partial release, then a clean re-press.
      up_q.delete();
      dn_q.delete();
      button_up = 1'b1;
      button_dn = 1'b1;
      tick(30);
      button_dn = 1'b0;
      tick(30);
      #1;
      check_int("simul_up_count", up_q.size(), 0);
      check_int("simul_dn_count", dn_q.size(), 0);
      button_up = 1'b0;
      tick(20);
      n = cyc + 1;
      button_up = 1'b1;
      tick(10);
      button_up = 1'b0;
      tick(20);
      #1;
      check_train("repress_up", up_q, n, {7});

      // Lockout arriving one cycle before the third up pulse.
      up_q.delete();
      dn_q.delete();
      n = cyc + 1;
      button_up = 1'b1;
      tick(28);
      button_dn = 1'b1;
      tick(30);
      button_up = 1'b0;
      button_dn = 1'b0;
      tick(20);
      #1;
      check_train("lock_up", up_q, n, {7, 27});
      check_int("lock_dn_count", dn_q.size(), 0);
      up_q.delete();
      n = cyc + 1;
      button_dn = 1'b1;
      tick(10);
      button_dn = 1'b0;
      tick(20);
      #1;
      check_train("after_lock_dn", dn_q, n, {7});
      check_int("after_lock_up_count", up_q.size(), 0);

      // Reset landing on the first repeat pulse while held.
      up_q.delete();
      dn_q.delete();
      n = cyc + 1;
      button_up = 1'b1;
      tick(27);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(15);
      button_up = 1'b0;
      tick(20);
      #1;
      check_train("midreset_up", up_q, n, {7, 35});
      check_int("midreset_dn_count", dn_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/press_pulser.md
# press_pulser

Button front end that produces the single-cycle `countu` / `countd` strobes consumed by the press counter. It takes two raw, asynchronous, bouncy push-button levels and synchronizes and debounces each one. For every accepted press it emits exactly one one-cycle pulse. Optionally it auto-repeats while the button is held. It sits between the board pins and the press counter, so the counter only ever sees clean, mutually exclusive one-cycle strobes.

## Interface
Parameters:
- `DebounceCycles`, default 16: consecutive stable cycles needed to accept a level change; legal range 1..255.
- `RepeatDelay`, default 64: cycles from the first pulse to the first repeat pulse; 0 disables auto-repeat; maximum 65535.
- `RepeatRate`, default 16: cycles between successive repeat pulses; legal range 1..65535.

Ports:
- `clock` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the rising edge of `clock`.
- `button_up` input 1: raw up button, active-high, asynchronous, may bounce.
- `button_dn` input 1: raw down button, same properties.
- `countu` output 1: one-cycle up strobe, registered.
- `countd` output 1: one-cycle down strobe, registered.

## Operation
- There are two identical channels (up, down), each containing a synchronizer, a debouncer and an FSM. Lockout logic couples the two channels.
- **Synchronizer:** two flip-flop stages per button; `sync` is the second stage.
- **Debouncer:**
  - It holds a debounced level `deb` and a counter `dcnt` (8 bits).
  - Each cycle in which `sync != deb`, `dcnt` increments.
  - When `dcnt` reaches `DebounceCycles`, `deb` takes the value of `sync` and `dcnt` clears.
  - Any cycle with `sync == deb` clears `dcnt`. A glitch shorter than `DebounceCycles` therefore never changes `deb`.
- **Channel FSM states:** IDLE, HELD, REPEAT, LOCK. A repeat counter `rcnt` (16 bits) runs alongside it.
- **Transitions:**
  - IDLE → HELD on a `deb` rising edge while the other channel's `deb` is low. The channel emits one pulse and clears `rcnt`.
  - IDLE → LOCK on a `deb` rising edge while the other channel's `deb` is high, or when both rising edges occur in the same cycle. No pulse.
  - HELD, `RepeatDelay` ≠ 0: `rcnt` increments each cycle. When `rcnt` reaches `RepeatDelay`, the channel emits a pulse, clears `rcnt` and moves to REPEAT.
  - HELD, `RepeatDelay` = 0: the channel stays in HELD and emits no further pulses.
  - REPEAT: `rcnt` increments. When `rcnt` reaches `RepeatRate`, the channel emits a pulse and clears `rcnt`.
  - HELD or REPEAT → IDLE when `deb` falls. No pulse, and `rcnt` clears.
  - HELD or REPEAT → LOCK when the other channel's `deb` goes high. There is no pulse in that cycle or later.
  - LOCK → IDLE only when its own `deb` falls. Releasing the other button does not resume pulsing.
- **Outputs:**
  - `countu` and `countd` are never high in the same cycle.
  - Every pulse lasts exactly one cycle.
  - Two pulses on the same channel are at least `RepeatRate` cycles apart.

## Timing
- **Reset:**
  - `countu` = 0 and `countd` = 0.
  - Both synchronizer stages, `deb`, `dcnt` and `rcnt` = 0.
  - Both FSMs go to IDLE.
  - A button already held when reset is released must still pass debounce and then pulses normally.
- **Reset mid-operation:** it aborts any pending repeat and takes precedence over all other events in that cycle.
- **Press latency:** a raw level that rises and stays stable is first sampled at edge N. The pulse appears at edge N + 2 + `DebounceCycles` + 1, is visible for that one cycle, and is low after edge N + `DebounceCycles` + 4.
- **Release latency:** `deb` falls 2 + `DebounceCycles` cycles after the raw level is first sampled low.
- **First repeat:** `RepeatDelay` cycles after the first pulse.
- **Later repeats:** every `RepeatRate` cycles.

## Test plan
Bench parameters: `DebounceCycles` = 4, `RepeatDelay` = 20, `RepeatRate` = 8.
- **Reset:** assert reset for 2 cycles with both buttons high. `countu` = `countd` = 0 during reset. After release, `countu` pulses once, 7 cycles after the first post-reset edge.
- **Clean press:** `button_up` high for 10 cycles, then low. Exactly one `countu` pulse, 7 cycles after the rise. `countd` stays 0.
- **Bounce:** `button_dn` toggles 1-0-1-0 every 2 cycles, then holds high for 12 cycles. No pulse during the toggling. Exactly one `countd` pulse, 7 cycles after the final rise.
- **Auto-repeat:** `button_up` held for 60 cycles. `countu` pulses at cycle 7 after the press, then at 27, 35, 43, 51 and 59 (6 pulses). No pulse after release.
- **Simultaneous press:**
  - Both buttons rise in the same cycle and are held 30 cycles: zero pulses on either output.
  - Then release `button_dn` while `button_up` stays high: still no `countu` pulse.
  - Re-press `button_up` after a full release: one pulse.
- **Lockout during repeat:**
  - Hold `button_up`. After its first pulse, press `button_dn` as well.
  - All pulses stop within 1 cycle of `deb_dn` rising.
  - Releasing both, then pressing `button_dn` alone, gives one `countd` pulse.
